// File: rtl/mem_arb_pkg.sv
// Shared types for the unified memory-port arbiter.
// Holds FSM state, owner tags and the latency-counter width.
package mem_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } owner_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/mem_arb.sv
// Fetch / data-stage arbiter for a single non-pipelined memory port.
// Ports: if_* fetch side, dm_* data side, mem_* memory command/return.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  output logic          if_err,
  input  logic          dm_req,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_err,
  output logic          mem_en,
  output logic          mem_wr,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_err
);

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MEM_LAT);
  localparam logic [CNT_W-1:0] SMAX = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  arb_state_t       state_q, state_d;
  owner_t           owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             wr_q, wr_d;

  logic ret;
  logic can_grant;
  logic pick_if;
  logic grant;

  // ret marks the cycle the memory presents data; it is
  // also a grant opportunity so back-to-back is seamless.
  assign ret       = (state_q == BUSY) && (cnt_q == ONE);
  assign can_grant = (state_q == IDLE) || ret;
  assign pick_if   = if_req && (!dm_req || starve_q == SMAX);
  assign grant     = rst && can_grant && (if_req || dm_req);
  assign if_gnt    = grant && pick_if;
  assign dm_gnt    = grant && !pick_if;

  always_comb begin
    mem_en    = grant;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      if_gnt: mem_addr = if_addr;
      dm_gnt: begin
        mem_wr    = dm_wr;
        mem_addr  = dm_addr;
        mem_wdata = dm_wdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    wr_d     = wr_q;
    starve_d = starve_q;
    if (state_q == BUSY) begin
      cnt_d = cnt_q - ONE;
      if (ret) state_d = IDLE;
    end
    if (can_grant) begin
      if (!if_req || if_gnt) starve_d = '0;
      else if (dm_gnt && starve_q != SMAX) starve_d = starve_q + ONE;
    end
    if (grant) begin
      state_d = BUSY;
      cnt_d   = LAT;
      owner_d = pick_if ? OWN_IF : OWN_DM;
      wr_d    = !pick_if && dm_wr;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      starve_q <= '0;
      owner_q  <= OWN_IF;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      owner_q  <= owner_d;
      wr_q     <= wr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      if_err    <= 1'b0;
      dm_rvalid <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
    end else begin
      if_rvalid <= ret && (owner_q == OWN_IF);
      dm_rvalid <= ret && (owner_q == OWN_DM);
      if (ret && owner_q == OWN_IF) begin
        if_rdata <= mem_rdata;
        if_err   <= mem_err;
      end
      if (ret && owner_q == OWN_DM) begin
        dm_rdata <= wr_q ? '0 : mem_rdata;
        dm_err   <= mem_err;
      end
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: vector table, directed corner sequences
// and per-requester response scoreboards on two latencies.
module tb_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic        a_if_req = 0, a_dm_req = 0, a_dm_wr = 0;
  logic [15:0] a_if_addr = 0, a_dm_addr = 0, a_dm_wdata = 0;
  logic        a_if_gnt, a_if_rvalid, a_if_err;
  logic        a_dm_gnt, a_dm_rvalid, a_dm_err;
  logic [15:0] a_if_rdata, a_dm_rdata;
  logic        a_mem_en, a_mem_wr, a_mem_err;
  logic [15:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

  logic        b_if_req = 0, b_dm_req = 0, b_dm_wr = 0;
  logic [15:0] b_if_addr = 0, b_dm_addr = 0, b_dm_wdata = 0;
  logic        b_if_gnt, b_if_rvalid, b_if_err;
  logic        b_dm_gnt, b_dm_rvalid, b_dm_err;
  logic [15:0] b_if_rdata, b_dm_rdata;
  logic        b_mem_en, b_mem_wr, b_mem_err;
  logic [15:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

  mem_arb #(.MEM_LAT(2), .STARVE_MAX(3)) u_a (
    .clk(clk), .rst(rst),
    .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
    .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata), .if_err(a_if_err),
    .dm_req(a_dm_req), .dm_wr(a_dm_wr), .dm_addr(a_dm_addr),
    .dm_wdata(a_dm_wdata), .dm_gnt(a_dm_gnt), .dm_rvalid(a_dm_rvalid),
    .dm_rdata(a_dm_rdata), .dm_err(a_dm_err),
    .mem_en(a_mem_en), .mem_wr(a_mem_wr), .mem_addr(a_mem_addr),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata), .mem_err(a_mem_err)
  );

  mem_arb #(.MEM_LAT(1), .STARVE_MAX(3)) u_b (
    .clk(clk), .rst(rst),
    .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
    .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata), .if_err(b_if_err),
    .dm_req(b_dm_req), .dm_wr(b_dm_wr), .dm_addr(b_dm_addr),
    .dm_wdata(b_dm_wdata), .dm_gnt(b_dm_gnt), .dm_rvalid(b_dm_rvalid),
    .dm_rdata(b_dm_rdata), .dm_err(b_dm_err),
    .mem_en(b_mem_en), .mem_wr(b_mem_wr), .mem_addr(b_mem_addr),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .mem_err(b_mem_err)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return a ^ 16'h1234;
  endfunction

  function automatic logic err_f(input logic [15:0] a);
    return a == 16'h0010;
  endfunction

  // Memory model: return the command address' data after the latency.
  logic [15:0] a_p0 = 0, a_p1 = 0, b_p0 = 0;
  always @(posedge clk) begin
    a_p0 <= a_mem_addr;
    a_p1 <= a_p0;
    b_p0 <= b_mem_addr;
  end
  assign a_mem_rdata = mem_f(a_p1);
  assign a_mem_err   = err_f(a_p1);
  assign b_mem_rdata = mem_f(b_p0);
  assign b_mem_err   = err_f(b_p0);

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t a_qi[$], a_qd[$], b_qi[$], b_qd[$];

  task automatic pop_chk(inout exp_t q[$], input string nm,
                         input logic [15:0] d, input logic e);
    exp_t x;
    if (q.size() == 0) begin
      chk({nm, "_unexpected"}, 1, 0);
    end else begin
      x = q.pop_front();
      chk({nm, "_data"}, {16'h0, d}, {16'h0, x.data});
      chk({nm, "_err"}, {31'h0, e}, {31'h0, x.err});
      chk({nm, "_lat"}, cyc, x.due);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      a_qi.delete(); a_qd.delete();
      b_qi.delete(); b_qd.delete();
    end else begin
      if (a_if_rvalid) pop_chk(a_qi, "a_if", a_if_rdata, a_if_err);
      if (a_dm_rvalid) pop_chk(a_qd, "a_dm", a_dm_rdata, a_dm_err);
      if (b_if_rvalid) pop_chk(b_qi, "b_if", b_if_rdata, b_if_err);
      if (b_dm_rvalid) pop_chk(b_qd, "b_dm", b_dm_rdata, b_dm_err);
      if (a_if_gnt)
        a_qi.push_back('{mem_f(a_if_addr), err_f(a_if_addr), cyc + 3});
      if (a_dm_gnt)
        a_qd.push_back('{a_dm_wr ? 16'h0 : mem_f(a_dm_addr),
                         err_f(a_dm_addr), cyc + 3});
      if (b_if_gnt)
        b_qi.push_back('{mem_f(b_if_addr), err_f(b_if_addr), cyc + 2});
      if (b_dm_gnt)
        b_qd.push_back('{b_dm_wr ? 16'h0 : mem_f(b_dm_addr),
                         err_f(b_dm_addr), cyc + 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        ir;
    logic [15:0] ia;
    logic        dr;
    logic        dw;
    logic [15:0] da;
    logic [15:0] dd;
    logic        eig;
    logic        edg;
    logic        een;
    logic        ewr;
    logic [15:0] ead;
    logic [15:0] ewd;
  } vec_t;

  vec_t vt[6];

  task automatic a_outs_zero(input string nm);
    chk({nm, "_if_gnt"}, {31'h0, a_if_gnt}, 0);
    chk({nm, "_dm_gnt"}, {31'h0, a_dm_gnt}, 0);
    chk({nm, "_mem_en"}, {31'h0, a_mem_en}, 0);
    chk({nm, "_mem_addr"}, {16'h0, a_mem_addr}, 0);
    chk({nm, "_rvalids"}, {30'h0, a_if_rvalid, a_dm_rvalid}, 0);
    chk({nm, "_if_rdata"}, {16'h0, a_if_rdata}, 0);
    chk({nm, "_dm_rdata"}, {16'h0, a_dm_rdata}, 0);
    chk({nm, "_errs"}, {30'h0, a_if_err, a_dm_err}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    int pulses;
    logic win[5];

    vt[0] = '{1, 16'h0004, 0, 0, 16'h0000, 16'h0000,
              1, 0, 1, 0, 16'h0004, 16'h0000};
    vt[1] = '{0, 16'h0000, 1, 0, 16'h0020, 16'h5555,
              0, 1, 1, 0, 16'h0020, 16'h5555};
    vt[2] = '{0, 16'h0000, 1, 1, 16'h0030, 16'hA5A5,
              0, 1, 1, 1, 16'h0030, 16'hA5A5};
    vt[3] = '{1, 16'h0006, 1, 0, 16'h0022, 16'h0000,
              0, 1, 1, 0, 16'h0022, 16'h0000};
    vt[4] = '{0, 16'h0008, 0, 0, 16'h0024, 16'h0000,
              0, 0, 0, 0, 16'h0000, 16'h0000};
    vt[5] = '{1, 16'h000A, 1, 1, 16'h0026, 16'h0F0F,
              0, 1, 1, 1, 16'h0026, 16'h0F0F};

    // Reset: requests present but nothing may leak out.
    a_if_req = 1; a_if_addr = 16'h0000;
    repeat (2) tick();
    a_outs_zero("rst");
    rst = 1;
    @(negedge clk);
    chk("t1_if_gnt", {31'h0, a_if_gnt}, 1);
    chk("t1_mem_en", {31'h0, a_mem_en}, 1);
    chk("t1_mem_addr", {16'h0, a_mem_addr}, 0);
    tick();
    a_if_req = 0;
    @(negedge clk);
    chk("t1_mem_en_t1", {31'h0, a_mem_en}, 0);
    @(negedge clk);
    chk("t1_rvalid_t2", {31'h0, a_if_rvalid}, 0);
    @(negedge clk);
    chk("t1_rvalid_t3", {31'h0, a_if_rvalid}, 1);
    chk("t1_rdata", {16'h0, a_if_rdata}, 32'h1234);
    repeat (3) tick();

    // Single-request and priority vectors from idle.
    for (int i = 0; i < 6; i++) begin
      a_if_req = vt[i].ir; a_if_addr = vt[i].ia;
      a_dm_req = vt[i].dr; a_dm_wr = vt[i].dw;
      a_dm_addr = vt[i].da; a_dm_wdata = vt[i].dd;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), {31'h0, a_if_gnt}, {31'h0, vt[i].eig});
      chk($sformatf("v%0d_dm_gnt", i), {31'h0, a_dm_gnt}, {31'h0, vt[i].edg});
      chk($sformatf("v%0d_mem_en", i), {31'h0, a_mem_en}, {31'h0, vt[i].een});
      chk($sformatf("v%0d_mem_wr", i), {31'h0, a_mem_wr}, {31'h0, vt[i].ewr});
      chk($sformatf("v%0d_addr", i), {16'h0, a_mem_addr}, {16'h0, vt[i].ead});
      chk($sformatf("v%0d_wdata", i), {16'h0, a_mem_wdata}, {16'h0, vt[i].ewd});
      tick();
      a_if_req = 0; a_dm_req = 0; a_dm_wr = 0;
      repeat (4) tick();
    end

    // Simultaneous requests: data first, fetch two cycles later.
    a_if_req = 1; a_if_addr = 16'h0100;
    a_dm_req = 1; a_dm_wr = 0; a_dm_addr = 16'h0040;
    @(negedge clk);
    chk("t2_dm_first", {30'h0, a_dm_gnt, a_if_gnt}, 32'h2);
    tick();
    a_dm_req = 0;
    @(negedge clk);
    chk("t2_if_wait", {31'h0, a_if_gnt}, 0);
    @(negedge clk);
    chk("t2_if_gnt", {31'h0, a_if_gnt}, 1);
    tick();
    a_if_req = 0;
    repeat (5) tick();

    // Anti-starvation with both requesters held high.
    a_if_req = 1; a_if_addr = 16'h0200;
    a_dm_req = 1; a_dm_wr = 0; a_dm_addr = 16'h0050;
    n = 0;
    for (int k = 0; k < 40 && n < 5; k++) begin
      @(negedge clk);
      if (a_dm_gnt) begin win[n] = 1; n++; end
      else if (a_if_gnt) begin win[n] = 0; n++; end
    end
    chk("t3_grants", n, 5);
    if (n == 5) begin
      chk("t3_g0_dm", {31'h0, win[0]}, 1);
      chk("t3_g1_dm", {31'h0, win[1]}, 1);
      chk("t3_g2_dm", {31'h0, win[2]}, 1);
      chk("t3_g3_if", {31'h0, win[3]}, 0);
      chk("t3_g4_dm", {31'h0, win[4]}, 1);
    end
    tick();
    a_if_req = 0; a_dm_req = 0;
    repeat (5) tick();

    // Data write returning a memory error.
    a_dm_req = 1; a_dm_wr = 1; a_dm_addr = 16'h0010; a_dm_wdata = 16'hBEEF;
    @(negedge clk);
    chk("t4_dm_gnt", {31'h0, a_dm_gnt}, 1);
    chk("t4_mem_wr", {31'h0, a_mem_wr}, 1);
    chk("t4_wdata", {16'h0, a_mem_wdata}, 32'hBEEF);
    chk("t4_addr", {16'h0, a_mem_addr}, 32'h0010);
    tick();
    a_dm_req = 0; a_dm_wr = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    chk("t4_dm_rvalid", {31'h0, a_dm_rvalid}, 1);
    chk("t4_dm_rdata", {16'h0, a_dm_rdata}, 0);
    chk("t4_dm_err", {31'h0, a_dm_err}, 1);
    chk("t4_if_rvalid", {31'h0, a_if_rvalid}, 0);
    chk("t4_if_rdata", {16'h0, a_if_rdata}, {16'h0, mem_f(16'h0200)});
    chk("t4_if_err", {31'h0, a_if_err}, 0);
    repeat (3) tick();

    // Reset one cycle after a fetch grant.
    a_if_req = 1; a_if_addr = 16'h0300;
    @(negedge clk);
    chk("t5_if_gnt", {31'h0, a_if_gnt}, 1);
    tick();
    a_if_req = 1; a_if_addr = 16'h0400;
    rst = 0;
    #1;
    a_outs_zero("t5_rst");
    tick();
    tick();
    rst = 1;
    @(negedge clk);
    chk("t5_regrant", {31'h0, a_if_gnt}, 1);
    chk("t5_regrant_addr", {16'h0, a_mem_addr}, 32'h0400);
    tick();
    a_if_req = 0;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_if_rvalid) pulses++;
    end
    chk("t5_one_rvalid", pulses, 1);
    tick();

    // MEM_LAT=1 back-to-back fetches.
    for (int i = 0; i < 5; i++) begin
      b_if_req = (i < 3);
      b_if_addr = 16'(2 * i);
      @(negedge clk);
      if (i < 3) chk($sformatf("t6_gnt%0d", i), {31'h0, b_if_gnt}, 1);
      if (i >= 2) chk($sformatf("t6_rv%0d", i), {31'h0, b_if_rvalid}, 1);
      tick();
    end
    b_if_req = 0;
    repeat (4) tick();

    chk("sb_empty", a_qi.size() + a_qd.size() + b_qi.size() + b_qd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
